// File: rtl/alu_seq.sv
// alu_seq: multi-cycle MUL/MULHU/DIVU/REMU/DIV/REM unit; define ALU_SEQ_SIGNED_DIV_EN for signed DIV/REM
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             cin,
  input  logic             vin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             vout,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_p;
  logic               r_cin;
  logic               r_vin;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_dout;
  logic               r_cout;
  logic               r_vout;
  logic               r_div_zero;
  logic               w_is_div;
  logic               w_ovf;
  logic               w_res_v;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dsh;
  logic [WIDTH:0]     w_ddif;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  assign w_is_div  = op[2] ^ op[1];
  assign w_lo      = r_p[WIDTH-1:0];
  assign w_hi      = r_p[2*WIDTH-1:WIDTH];
  assign w_msum    = {1'b0, w_hi} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_msum, r_p[WIDTH-1:1]};
  assign w_dsh     = {w_hi, r_p[WIDTH-1]};
  assign w_ddif    = w_dsh - {1'b0, r_b};
  assign w_div_nxt = {w_ddif[WIDTH] ? w_dsh[WIDTH-1:0] : w_ddif[WIDTH-1:0], r_p[WIDTH-2:0], ~w_ddif[WIDTH]};
`ifdef ALU_SEQ_SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf;
  logic w_sgn;
  assign w_sgn   = op[2:1] == 2'b10;
  assign w_a_mag = (w_sgn && din_a[WIDTH-1]) ? -din_a : din_a;
  assign w_b_mag = (w_sgn && din_b[WIDTH-1]) ? -din_b : din_b;
  assign w_quo   = r_dz ? {WIDTH{1'b1}} : r_neg_q ? -w_lo : w_lo;
  assign w_rem   = r_dz ? r_a : r_neg_r ? -w_hi : w_hi;
  assign w_ovf   = r_ovf;
`else
  assign w_a_mag = din_a;
  assign w_b_mag = din_b;
  assign w_quo   = r_dz ? {WIDTH{1'b1}} : w_lo;
  assign w_rem   = r_dz ? r_a : w_hi;
  assign w_ovf   = 1'b0;
`endif
  assign w_res    = &r_op[2:1] ? r_b : r_op[0] ? w_hi : w_lo;
  assign w_res_v  = r_op == 3'b000 ? |w_hi : r_op == 3'b001 ? 1'b0 : (r_dz | w_ovf) ? 1'b1 : r_vin;
  assign busy     = r_busy;
  assign done     = r_done;
  assign dout     = r_dout;
  assign cout     = r_cout;
  assign vout     = r_vout;
  assign div_zero = r_div_zero;
  // sequencer: latch at issue, one shift step per RUN clock, two-clock FIX (sign fix, then publish)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_p        <= '0;
      r_cin      <= 1'b0;
      r_vin      <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dout     <= '0;
      r_cout     <= 1'b0;
      r_vout     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(WIDTH);
            r_op    <= op;
            r_a     <= din_a;
            r_b     <= w_is_div ? w_b_mag : din_b;
            r_p     <= {{WIDTH{1'b0}}, w_is_div ? w_a_mag : din_b};
            r_cin   <= cin;
            r_vin   <= vin;
            r_dz    <= w_is_div && din_b == '0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            r_neg_q <= w_sgn && (din_a[WIDTH-1] ^ din_b[WIDTH-1]);
            r_neg_r <= w_sgn && din_a[WIDTH-1];
            r_ovf   <= w_sgn && din_a == {1'b1, {(WIDTH-1){1'b0}}} && &din_b;
`endif
          end
        end
        RUN: begin
          r_p   <= r_op[2:1] == 2'b00 ? w_mul_nxt : w_div_nxt;
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE) r_state <= FIX;
        end
        FIX: begin
          if (!r_cnt[0]) begin
            r_p   <= {w_rem, w_quo};
            r_cnt <= ONE;
          end else begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_dout     <= w_res;
            r_cout     <= r_cin;
            r_vout     <= w_res_v;
            r_div_zero <= r_dz;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        start = 1'b0, cin = 1'b0, vin = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        busy, done, cout, vout, div_zero;
  logic [31:0] dout;
  logic        start8 = 1'b0, cin8 = 1'b0, vin8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, vout8, dz8;
  logic [7:0]  dout8;
  int          n_cmp = 0, n_mis = 0;
  logic [33:0] last_exp = '0;
  alu_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .din_a(din_a), .din_b(din_b),
    .cin(cin), .vin(vin), .busy(busy), .done(done), .dout(dout), .cout(cout),
    .vout(vout), .div_zero(div_zero)
  );
  alu_seq #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .din_a(a8), .din_b(b8),
    .cin(cin8), .vin(vin8), .busy(busy8), .done(done8), .dout(dout8), .cout(cout8),
    .vout(vout8), .div_zero(dz8)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // returns {div_zero, vout, dout}
  function automatic logic [33:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic vi);
    logic [63:0] p;
    logic [31:0] q, r;
    logic dz, ov, sg;
    p  = {32'd0, a} * {32'd0, b};
    sg = 1'b0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
    sg = o[2:1] == 2'b10;
`endif
    dz = (o[2] ^ o[1]) && b == 32'd0;
    ov = vi;
    if (b == 32'd0) begin
      q = '1; r = a; ov = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; ov = 1'b1;
    end else if (sg) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    case (o)
      3'd0:       return {1'b0, |p[63:32], p[31:0]};
      3'd1:       return {1'b0, 1'b0, p[63:32]};
      3'd2, 3'd4: return {dz, ov, q};
      3'd3, 3'd5: return {dz, ov, r};
      default:    return {1'b0, vi, b};
    endcase
  endfunction
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input logic v, input logic [33:0] exp);
    int lat;
    @(negedge clk);
    op = o; din_a = a; din_b = b; cin = c; vin = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); din_a = $urandom; din_b = $urandom; cin = 1'($urandom); vin = 1'($urandom);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".hold"}, dout, last_exp[31:0]);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, 34);
    chk({tag, ".dout"}, dout, exp[31:0]);
    chk({tag, ".vout"}, vout, exp[32]);
    chk({tag, ".dz"}, div_zero, exp[33]);
    chk({tag, ".cout"}, cout, c);
    chk({tag, ".busy0"}, busy, 0);
    last_exp = exp;
  endtask
  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic ev);
    int lat;
    @(negedge clk);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, 10);
    chk({tag, ".dout"}, dout8, ed);
    chk({tag, ".vout"}, vout8, ev);
    chk({tag, ".dz"}, dz8, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nd;
    logic [2:0] o;
    logic [31:0] a, b;
    logic c, v;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.dout", dout, 0);
    chk("rst.vout", vout, 0);
    chk("rst.cout", cout, 0);
    chk("rst.dz", div_zero, 0);
    chk("rst.busy8", busy8, 0);
    @(negedge clk);
    rst = 1'b0;
    run("mul", 3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, {2'b01, 32'h0000_0000});
    run("mulhu", 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, {2'b00, 32'h0000_0001});
    run("divu", 3'd2, 32'd100, 32'd7, 1'b1, 1'b0, {2'b00, 32'd14});
    run("remu", 3'd3, 32'd100, 32'd7, 1'b1, 1'b0, {2'b00, 32'd2});
    run("divu0", 3'd2, 32'h1234, 32'd0, 1'b0, 1'b0, {2'b11, 32'hFFFF_FFFF});
    run("remu0", 3'd3, 32'h1234, 32'd0, 1'b0, 1'b0, {2'b11, 32'h0000_1234});
    run("rsv", 3'd6, 32'h5555_0000, 32'hCAFE_F00D, 1'b1, 1'b1, {2'b01, 32'hCAFE_F00D});
`ifdef ALU_SEQ_SIGNED_DIV_EN
    run("div_s", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, {2'b00, 32'hFFFF_FFFD});
    run("rem_s", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, {2'b00, 32'hFFFF_FFFF});
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, {2'b01, 32'h8000_0000});
`else
    run("div_u", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, {2'b00, 32'h7FFF_FFFC});
    run("rem_u", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, {2'b00, 32'h0000_0001});
`endif
    @(negedge clk);
    op = 3'd0; din_a = 32'd3; din_b = 32'd5; cin = 1'b0; vin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 20);
      if (i == 20) begin
        op = 3'd1; din_a = 32'd7; din_b = 32'd9;
      end
      @(posedge clk); #1;
      if (done) nd++;
    end
    start = 1'b0;
    chk("ign.ndone", nd, 1);
    chk("ign.dout", dout, 32'd15);
    chk("ign.busy", busy, 0);
    last_exp = {2'b00, 32'd15};
    @(negedge clk);
    op = 3'd2; din_a = 32'd1000; din_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rmid.busy", busy, 0);
    chk("rmid.done", done, 0);
    chk("rmid.dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rmid.ndone", nd, 0);
    last_exp = '0;
    run8("w8.mul", 3'd0, 8'hFF, 8'hFF, 8'h01, 1'b1);
    run8("w8.mulhu", 3'd1, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    run8("w8.divu", 3'd2, 8'd200, 8'd7, 8'd28, 1'b0);
    for (int k = 0; k < 250; k++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      c = 1'($urandom);
      v = 1'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      run("rnd", o, a, b, c, v, model(o, a, b, v));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
